pattern_history_table: RTL and testbench

Table of 2-bit saturating branch-direction counters read in fetch and trained in decode. Fetch presents the table index each cycle and gets the counter state combinationally. The fetch-side predictor uses `state[1]` as the taken prediction. The block carries the fetch index into decode internally, so the decode-stage update trains the same entry that produced the prediction.

---
 rtl/pattern_history_table.sv | 74 +++++++
 tb/tb_pattern_history_table.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pattern_history_table.sv
// Bimodal 2-bit saturating branch-direction table: fetch-side combinational read, decode-side training.
// Define PHT_GSHARE_EN to hash the read index with a global history register (gshare).
module pattern_history_table #(
    parameter int INDEX_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic [INDEX_WIDTH-1:0] index_f,
    input  logic                   update_en,
    input  logic                   taken_d,
    output logic [1:0]             state,
    output logic [INDEX_WIDTH-1:0] index_d
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;

    logic [1:0]             r_table [ENTRIES];
    logic [INDEX_WIDTH-1:0] r_index_d;
    logic                   r_valid_d;
    logic [INDEX_WIDTH-1:0] w_rd_idx;
    logic                   w_commit;
    logic [1:0]             w_cur;
    logic [1:0]             w_trained;

`ifdef PHT_GSHARE_EN
    logic [INDEX_WIDTH-1:0] r_ghr;

    assign w_rd_idx = index_f ^ r_ghr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ghr <= '0;
        else if (w_commit)
            r_ghr <= {r_ghr[INDEX_WIDTH-2:0], taken_d};
    end
`else
    assign w_rd_idx = index_f;
`endif

    // en gate keeps a stalled update_en from training the entry more than once
    assign w_commit = update_en & en & r_valid_d;
    assign w_cur    = r_table[r_index_d];

    always_comb begin
        w_trained = w_cur;
        if (taken_d) begin
            if (w_cur != 2'b11) w_trained = w_cur + 2'd1;
        end else begin
            if (w_cur != 2'b00) w_trained = w_cur - 2'd1;
        end
    end

    // Same-cycle write to the entry being read is forwarded to fetch
    assign state   = (w_commit && (r_index_d == w_rd_idx)) ? w_trained : r_table[w_rd_idx];
    assign index_d = r_index_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index_d <= '0;
            r_valid_d <= 1'b0;
            for (int i = 0; i < ENTRIES; i++)
                r_table[i] <= 2'b01;
        end else begin
            if (en) begin
                r_index_d <= w_rd_idx;
                r_valid_d <= !flush;
            end
            if (w_commit)
                r_table[r_index_d] <= w_trained;
        end
    end

endmodule

// File: tb/tb_pattern_history_table.sv
// Directed bench for pattern_history_table: reset, saturation, bypass, stall, flush, mid-run reset.
module tb_pattern_history_table;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic [IW-1:0] index_f;
    logic          update_en;
    logic          taken_d;
    logic [1:0]    state;
    logic [IW-1:0] index_d;

    int checks = 0;
    int errors = 0;

    pattern_history_table #(.INDEX_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .index_f   (index_f),
        .update_en (update_en),
        .taken_d   (taken_d),
        .state     (state),
        .index_d   (index_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] sat_exp [9];
    int bad;

    initial begin
        sat_exp[0] = 2'b10; sat_exp[1] = 2'b11; sat_exp[2] = 2'b11; sat_exp[3] = 2'b11;
        sat_exp[4] = 2'b10; sat_exp[5] = 2'b01; sat_exp[6] = 2'b00; sat_exp[7] = 2'b00;
        sat_exp[8] = 2'b00;

        rst = 1'b1; en = 1'b1; flush = 1'b0; index_f = 10'h155; update_en = 1'b0; taken_d = 1'b0;
        #12;
        chk("rst_index_d", 32'(index_d), 32'h0);
        chk("rst_state", 32'(state), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Saturation on 0x155: four taken then five not-taken
        step();
        index_f = 10'h155;
        step();
        update_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            taken_d = (i < 4);
            #1;
            chk($sformatf("sat%0d", i), 32'(state), 32'(sat_exp[i]));
            step();
        end
        update_en = 1'b0;

        // Bypass on 0x020
        index_f = 10'h020;
        step();
        update_en = 1'b1; taken_d = 1'b1;
        #1;
        chk("byp_same", 32'(state), 32'h2);
        step();
        update_en = 1'b0;
        #1;
        chk("byp_next", 32'(state), 32'h2);

        // Stall with update_en held on 0x007
        index_f = 10'h007;
        step();
        en = 1'b0; update_en = 1'b1; taken_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall_idx%0d", i), 32'(index_d), 32'h007);
            chk($sformatf("stall_st%0d", i), 32'(state), 32'h1);
            step();
        end
        en = 1'b1;
        #1;
        chk("stall_commit", 32'(state), 32'h2);
        step();
        update_en = 1'b0;
        #1;
        chk("stall_once", 32'(state), 32'h2);

        // Flush squashes captured fetch of 0x3FF
        index_f = 10'h3FF; flush = 1'b1;
        step();
        flush = 1'b0; update_en = 1'b1; taken_d = 1'b1;
        #1;
        chk("flush_idx", 32'(index_d), 32'h3FF);
        chk("flush_nobyp", 32'(state), 32'h1);
        step();
        update_en = 1'b0;
        #1;
        chk("flush_keep", 32'(state), 32'h1);

        // Flush together with a commit of the current decode instruction
        index_f = 10'h0AA;
        step();
        flush = 1'b1; update_en = 1'b1; taken_d = 1'b1;
        #1;
        chk("fc_commit", 32'(state), 32'h2);
        step();
        flush = 1'b0;
        #1;
        chk("fc_squash", 32'(state), 32'h2);
        step();
        update_en = 1'b0;
        #1;
        chk("fc_after", 32'(state), 32'h2);

        // Mid-cycle reset with an update pending on 0x155 (currently 00)
        index_f = 10'h155;
        step();
        update_en = 1'b1; taken_d = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_index_d", 32'(index_d), 32'h0);
        update_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            index_f = i[IW-1:0];
            #1;
            if (state !== 2'b01) bad++;
        end
        chk("mrst_sweep_bad", 32'(bad), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        index_f = 10'h155;
        #1;
        chk("mrst_155", 32'(state), 32'h1);

`ifdef PHT_GSHARE_EN
        // ghr: T,T,N -> 0x006; entry 0 decremented by the third commit
        index_f = 10'h001;
        step();
        update_en = 1'b1; taken_d = 1'b1;
        step();
        step();
        taken_d = 1'b0;
        step();
        update_en = 1'b0;
        index_f = 10'h00F;
        step();
        chk("gs_index_d", 32'(index_d), 32'h009);
        index_f = 10'h006;
        #1;
        chk("gs_entry0", 32'(state), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
